// File: rtl/sram_mem_stage_ctrl_pkg.sv
// Shared configuration for the Mem-stage SRAM controller: default widths, base address,
// FSM state encodings and a helper for sizing the beat counter.
package sram_mem_stage_ctrl_pkg;

    localparam int DEF_WORD_LEN    = 32;
    localparam int DEF_ADDRESS_LEN = 32;
    localparam int DEF_BASE_ADDR   = 1024;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // A single-beat configuration still needs a one-bit beat index.
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sram_mem_stage_ctrl_beat_seq.sv
// Wait/beat counters for one SRAM word access; start launches a sequence of BEATS beats,
// each WAIT_CYCLES long, and the counters return to zero once the final beat ends.
module sram_beat_sequencer
    import sram_mem_stage_ctrl_pkg::*;
#(
    parameter int BEATS       = 2,
    parameter int WAIT_CYCLES = 3,
    parameter int BEAT_W      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [BEAT_W-1:0] beat,
    output logic              last_wait,
    output logic              last_beat
);

    localparam int WAIT_W = $clog2(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    logic              running;
    logic [WAIT_W-1:0] wait_cnt;

    assign last_wait = running && (wait_cnt == WAIT_LAST);
    assign last_beat = (beat == BEAT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            wait_cnt <= '0;
            beat     <= '0;
        end else if (start) begin
            running  <= 1'b1;
            wait_cnt <= '0;
            beat     <= '0;
        end else if (running) begin
            if (wait_cnt == WAIT_LAST) begin
                wait_cnt <= '0;
                if (last_beat) begin
                    beat    <= '0;
                    running <= 1'b0;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_mem_stage_ctrl.sv
// Multi-cycle Mem-stage controller splitting each CPU word access into narrow SRAM beats.
// Optional one-entry read buffer enabled by defining READ_BUFFER_EN.
module sram_mem_stage_ctrl
    import sram_mem_stage_ctrl_pkg::*;
#(
    parameter int WORD_LEN    = DEF_WORD_LEN,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WORD_LEN-1:0]    addr,
    input  logic [WORD_LEN-1:0]    wdata,
    output logic [WORD_LEN-1:0]    rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in
);

    localparam int BEATS      = WORD_LEN / SRAM_DQ_W;
    localparam int BEAT_W     = beat_width(BEATS);
    localparam int BYTE_SHIFT = $clog2(WORD_LEN / 8);

    logic [1:0]          state;
    logic                op_wr;
    logic [WORD_LEN-1:0] lat_addr;
    logic [WORD_LEN-1:0] lat_wdata;
    logic [WORD_LEN-1:0] offset;
    logic                req;
    logic                seq_start;
    logic [BEAT_W-1:0]   beat;
    logic                last_wait;
    logic                last_beat;
    logic                buf_hit;
    logic [WORD_LEN-1:0] buf_rd_data;
    logic                unused_bits;

    assign req       = rd_en | wr_en;
    assign ready     = ~req | (state == DONE);
    assign seq_start = (state == IDLE) && req && !buf_hit;
    assign offset    = lat_addr - WORD_LEN'(BASE_ADDR);
    assign unused_bits = ^offset;

    sram_beat_sequencer #(
        .BEATS       (BEATS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BEAT_W      (BEAT_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (seq_start),
        .beat      (beat),
        .last_wait (last_wait),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr     <= wr_en;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        state     <= buf_hit ? DONE : ACCESS;
                        if (buf_hit) rdata <= buf_rd_data;
                    end
                end
                ACCESS: begin
                    if (!op_wr && last_wait)
                        rdata[beat*SRAM_DQ_W +: SRAM_DQ_W] <= sram_dq_in;
                    if (last_wait && last_beat) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The last wait cycle of a write beat releases we_n while address and data stay put.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        if (state == ACCESS) begin
            sram_addr = {offset[BYTE_SHIFT +: SRAM_ADDR_W-BEAT_W], beat};
            if (op_wr) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = lat_wdata[beat*SRAM_DQ_W +: SRAM_DQ_W];
                sram_we_n   = last_wait;
            end
        end
    end

`ifdef READ_BUFFER_EN
    logic                           buf_valid;
    logic [WORD_LEN-BYTE_SHIFT-1:0] buf_addr;
    logic [WORD_LEN-1:0]            buf_data;

    assign buf_hit     = buf_valid && rd_en && !wr_en && (buf_addr == addr[WORD_LEN-1:BYTE_SHIFT]);
    assign buf_rd_data = buf_data;

    // Reads refill at DONE (a hit refills with the same word); writes to the entry write through.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (state == DONE) begin
            if (!op_wr) begin
                buf_valid <= 1'b1;
                buf_addr  <= lat_addr[WORD_LEN-1:BYTE_SHIFT];
                buf_data  <= rdata;
            end else if (buf_valid && buf_addr == lat_addr[WORD_LEN-1:BYTE_SHIFT]) begin
                buf_data <= lat_wdata;
            end
        end
    end
`else
    assign buf_hit     = 1'b0;
    assign buf_rd_data = '0;
`endif

endmodule

// File: tb/tb_sram_mem_stage_ctrl.sv
// Scoreboard bench for sram_mem_stage_ctrl with a behavioural asynchronous SRAM model;
// expectations adapt when READ_BUFFER_EN is defined.
module tb_sram_mem_stage_ctrl;

`ifdef READ_BUFFER_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 7;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    logic [15:0] mem [0:262143];

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          welow;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    int   lat_cnt = 0;
    int   welow_cnt = 0;

    always #5 clk = ~clk;

    sram_mem_stage_ctrl #(
        .WORD_LEN    (32),
        .SRAM_DQ_W   (16),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (3),
        .BASE_ADDR   (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = mem[sram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts stalled cycles and write strobes, checks on the DONE cycle.
    always @(negedge clk) begin
        if (rst) begin
            lat_cnt   = 0;
            welow_cnt = 0;
        end else if (rd_en || wr_en) begin
            if (!ready) begin
                lat_cnt++;
                if (!sram_we_n) welow_cnt++;
            end else begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    e_mon = sb.pop_front();
                    check({e_mon.name, "_rdata"}, rdata, e_mon.rdata);
                    check({e_mon.name, "_lat"}, lat_cnt, e_mon.lat);
                    check({e_mon.name, "_welow"}, welow_cnt, e_mon.welow);
                end
                lat_cnt   = 0;
                welow_cnt = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got ready=0 expected ready=1 within 100 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input int exp_lat, input int exp_welow,
                          input string name);
        sb.push_back('{exp_rd, exp_lat, exp_welow, name});
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        wait_done(name);
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_rdata", rdata, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_we_n", sram_we_n, 1);
        end
        @(posedge clk);
        #1;

        access(1, 0, 32'd1024, 32'hDEADBEEF, 32'h0, 7, 4, "st_1024");
        check("mem0_beef", mem[0], 32'hBEEF);
        check("mem1_dead", mem[1], 32'hDEAD);
        idle();

        access(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 7, 0, "ld_1024");
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("rdata_after_done", rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        access(1, 0, 32'd1028, 32'd5, 32'hDEADBEEF, 7, 4, "st_1028");
        access(0, 1, 32'd1028, 32'h0, 32'd5, 7, 0, "ld_1028");
        check("mem2", mem[2], 32'h5);
        check("mem3", mem[3], 32'h0);
        idle();

        access(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 7, 0, "ld_1024_fill");
        idle();
        access(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, HIT_LAT, 0, "ld_1024_rep");
        idle();

        access(1, 0, 32'd1024, 32'h1234, 32'hDEADBEEF, 7, 4, "st_1234");
        idle();
        access(0, 1, 32'd1024, 32'h0, 32'h1234, HIT_LAT, 0, "ld_1234");
        check("mem0_1234", mem[0], 32'h1234);
        check("mem1_zero", mem[1], 32'h0);
        idle();

        access(1, 0, 32'd1020, 32'hCAFEF00D, 32'h1234, 7, 4, "st_wrap");
        check("mem_wrap_lo", mem[18'h3FFFE], 32'hF00D);
        check("mem_wrap_hi", mem[18'h3FFFF], 32'hCAFE);
        idle();
        access(0, 1, 32'd1020, 32'h0, 32'hCAFEF00D, 7, 0, "ld_wrap");
        idle();

        wr_en = 1'b1; rd_en = 1'b0; addr = 32'd1032; wdata = 32'h11112222;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.push_back('{32'h0, 7, 4, "st_after_rst"});
        @(negedge clk);
        check("rst_mid_ready", ready, 0);
        check("rst_mid_we_n", sram_we_n, 1);
        check("rst_mid_oe", sram_dq_oe, 0);
        wait_done("st_after_rst");
        check("mem4", mem[4], 32'h2222);
        check("mem5", mem[5], 32'h1111);
        idle();
        access(0, 1, 32'd1024, 32'h0, 32'h1234, 7, 0, "ld_after_rst");
        idle();

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
